mux_scan: RTL and testbench

Parametrised, registered N-channel, W-bit multiplexer with two modes: manual selection and timed auto-scan. In auto-scan it steps through the channels on its own, for example to time-multiplex several digit values onto one display bus. It is the sequential successor of the combinational 8:1 × 5-bit channel mux. It sits between the value-producing datapath and the shared output bus or display driver.

---
 rtl/mux_scan.sv | 188 ++++++++++++++++++
 tb/tb_mux_scan.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan.sv
// mux_scan -- registered N-channel, W-bit multiplexer with manual select and timed auto-scan.
//
// Purpose:
//   In manual mode the channel addressed by sel is registered onto data_out.
//   In auto-scan mode an internal index steps through the channels on its own.
//   Each channel stays selected for DWELL non-hold cycles, and wrap pulses
//   when the sweep comes back round.
//   Typical use is time-multiplexing digit values onto one display bus.
//
// Parameters:
//   WIDTH    bits per channel
//   CHANNELS number of input channels (>= 2)
//   SEL_W    select/index width, 2**SEL_W >= CHANNELS
//   DWELL    cycles each channel stays selected in scan mode (>= 1)
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   mode      in   0 = manual, 1 = auto-scan
//   sel       in   manual channel index
//   hold      in   freezes all state while high
//   chan_mask in   per-channel scan enable (only with MUX_SCAN_MASK_EN)
//   data_in   in   channel k at bits [k*WIDTH +: WIDTH]
//   data_out  out  registered selected channel
//   ch_out    out  index of the channel on data_out
//   valid     out  data_out holds a legitimate channel sample
//   wrap      out  one-cycle pulse, aligned with the first sample after the
//                  scan index wrapped
//
// Build option:
//   MUX_SCAN_MASK_EN  when defined, scan skips channels whose chan_mask bit is 0.
//                     When undefined, chan_mask is ignored.

module mux_scan #(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3,
  parameter int DWELL    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      hold,
  input  logic [CHANNELS-1:0]       chan_mask,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  output logic [WIDTH-1:0]          data_out,
  output logic [SEL_W-1:0]          ch_out,
  output logic                      valid,
  output logic                      wrap
);

  localparam int               CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int               LEAVES   = 1 << SEL_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CHANNELS - 1);
  localparam logic [SEL_W:0]   CH_LIMIT = (SEL_W + 1)'(CHANNELS);

  logic [WIDTH-1:0] r_data_out;
  logic [SEL_W-1:0] r_ch_out;
  logic             r_valid;
  logic             r_wrap;
  logic             r_wrap_pend;
  logic [SEL_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;

  logic [SEL_W-1:0] w_sel;
  logic             w_sel_ok;
  logic             w_any_en;
  logic [SEL_W-1:0] w_next_idx;
  logic [WIDTH-1:0] w_tree [0:2*LEAVES-2];

  // Next enabled channel after cur in circular order. It returns cur itself
  // when cur is the only enabled channel.
  function automatic logic [SEL_W-1:0] next_masked(input logic [SEL_W-1:0]    cur,
                                                   input logic [CHANNELS-1:0] mask);
    logic [SEL_W-1:0]    result;
    logic                found;
    logic [CHANNELS-1:0] shifted;
    int                  cand;
    result = cur;
    found  = 1'b0;
    for (int k = 1; k <= CHANNELS; k++) begin
      cand = int'(cur) + k;
      if (cand >= CHANNELS) begin
        cand = cand - CHANNELS;
      end else begin
        cand = cand;
      end
      shifted = mask >> cand;
      if (!found && shifted[0]) begin
        result = SEL_W'(cand);
        found  = 1'b1;
      end else begin
        found = found;
      end
    end
    return result;
  endfunction

  // The mux tree uses the scan index in scan mode and sel in manual mode.
  assign w_sel    = mode ? r_idx : sel;
  assign w_sel_ok = ({1'b0, sel} < CH_LIMIT);

`ifdef MUX_SCAN_MASK_EN
  assign w_any_en   = |chan_mask;
  assign w_next_idx = next_masked(r_idx, chan_mask);
`else
  logic w_unused_mask;
  assign w_unused_mask = ^chan_mask;
  assign w_any_en      = 1'b1;
  assign w_next_idx    = (r_idx == LAST_IDX) ? {SEL_W{1'b0}} : (r_idx + SEL_W'(1));
`endif

  // Balanced binary mux tree in heap order. The root is w_tree[0], and leaf j
  // is w_tree[LEAVES-1+j]. Depth d is steered by select bit SEL_W-1-d, so the
  // MSB is decided at the root. Leaves beyond CHANNELS are tied to zero.
  genvar g_j, g_d, g_n;
  generate
    for (g_j = 0; g_j < LEAVES; g_j++) begin : g_leaf
      if (g_j < CHANNELS) begin : g_real
        assign w_tree[LEAVES-1+g_j] = data_in[g_j*WIDTH +: WIDTH];
      end else begin : g_pad
        assign w_tree[LEAVES-1+g_j] = {WIDTH{1'b0}};
      end
    end
    for (g_d = 0; g_d < SEL_W; g_d++) begin : g_level
      for (g_n = (1 << g_d) - 1; g_n < (1 << (g_d + 1)) - 1; g_n++) begin : g_node
        assign w_tree[g_n] = w_sel[SEL_W-1-g_d] ? w_tree[2*g_n+2] : w_tree[2*g_n+1];
      end
    end
  endgenerate

  // Output registers, scan index and dwell counter.
  // r_wrap_pend remembers that the index just wrapped, so that the wrap pulse
  // lines up with the first sample of the new sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out  <= {WIDTH{1'b0}};
      r_ch_out    <= {SEL_W{1'b0}};
      r_valid     <= 1'b0;
      r_wrap      <= 1'b0;
      r_wrap_pend <= 1'b0;
      r_idx       <= {SEL_W{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
    end else if (hold) begin
      r_wrap <= 1'b0;
    end else if (!mode) begin
      r_idx       <= {SEL_W{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_wrap      <= 1'b0;
      r_wrap_pend <= 1'b0;
      if (w_sel_ok) begin
        r_data_out <= w_tree[0];
        r_ch_out   <= sel;
        r_valid    <= 1'b1;
      end else begin
        r_data_out <= {WIDTH{1'b0}};
        r_valid    <= 1'b0;
      end
    end else if (!w_any_en) begin
      // Nothing enabled: park the scan and flag the output as not valid.
      r_data_out  <= {WIDTH{1'b0}};
      r_valid     <= 1'b0;
      r_wrap      <= 1'b0;
      r_wrap_pend <= 1'b0;
    end else begin
      r_data_out <= w_tree[0];
      r_ch_out   <= r_idx;
      r_valid    <= 1'b1;
      r_wrap     <= r_wrap_pend;
      if (r_cnt == LAST_CNT) begin
        r_cnt       <= {CNT_W{1'b0}};
        r_idx       <= w_next_idx;
        r_wrap_pend <= (w_next_idx <= r_idx);
      end else begin
        r_cnt       <= r_cnt + CNT_W'(1);
        r_wrap_pend <= 1'b0;
      end
    end
  end

  assign data_out = r_data_out;
  assign ch_out   = r_ch_out;
  assign valid    = r_valid;
  assign wrap     = r_wrap;

endmodule

// File: tb/tb_mux_scan.sv
// Testbench for mux_scan with default parameters (instance u_a), plus a
// CHANNELS=6 instance (u_b) for out-of-range select behaviour.
// The reference model counts non-hold scan cycles and derives the channel
// and wrap with plain arithmetic.

module tb_mux_scan;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: defaults (WIDTH 5, CHANNELS 8, SEL_W 3, DWELL 4).
  logic        a_mode, a_hold;
  logic [2:0]  a_sel;
  logic [7:0]  a_mask;
  logic [39:0] a_data;
  logic [4:0]  a_dout;
  logic [2:0]  a_ch;
  logic        a_valid, a_wrap;

  // Instance B: CHANNELS = 6.
  logic [2:0]  b_sel;
  logic [5:0]  b_mask;
  logic [29:0] b_data;
  logic [4:0]  b_dout;
  logic [2:0]  b_ch;
  logic        b_valid, b_wrap;
  logic        b_mode, b_hold;

  mux_scan u_a (
    .clk(clk), .rst_n(rst_n), .mode(a_mode), .sel(a_sel), .hold(a_hold),
    .chan_mask(a_mask), .data_in(a_data), .data_out(a_dout), .ch_out(a_ch),
    .valid(a_valid), .wrap(a_wrap)
  );

  mux_scan #(.WIDTH(5), .CHANNELS(6), .SEL_W(3), .DWELL(4)) u_b (
    .clk(clk), .rst_n(rst_n), .mode(b_mode), .sel(b_sel), .hold(b_hold),
    .chan_mask(b_mask), .data_in(b_data), .data_out(b_dout), .ch_out(b_ch),
    .valid(b_valid), .wrap(b_wrap)
  );

  // Reference model state for instance A.
  logic [4:0] m_data;
  logic [2:0] m_ch;
  logic       m_valid, m_wrap;
  int         m_t;   // non-hold scan cycles since the scan (re)started

  task automatic model_reset();
    m_data = 5'd0; m_ch = 3'd0; m_valid = 1'b0; m_wrap = 1'b0; m_t = 0;
  endtask

  // Predict instance A outputs after the coming edge, from the current inputs.
  task automatic model_edge();
    int c;
    if (a_hold) begin
      m_wrap = 1'b0;
    end else if (!a_mode) begin
      m_t    = 0;
      m_wrap = 1'b0;
      if (int'(a_sel) < 8) begin
        m_data  = a_data[int'(a_sel)*5 +: 5];
        m_ch    = a_sel;
        m_valid = 1'b1;
      end else begin
        m_data  = 5'd0;
        m_valid = 1'b0;
      end
    end else begin
      c       = (m_t / 4) % 8;
      m_data  = a_data[c*5 +: 5];
      m_ch    = 3'(c);
      m_valid = 1'b1;
      m_wrap  = (m_t > 0) && ((m_t % 32) == 0);
      m_t     = m_t + 1;
    end
  endtask

  task automatic clk_edge();
    @(posedge clk);
    #1;
  endtask

  // Reset with rst_n released between clock edges.
  task automatic do_reset(input logic scan);
    rst_n  = 1'b0;
    a_mode = scan;
    a_hold = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_mode = 1'b0; a_hold = 1'b0; a_sel = 3'd1; a_mask = 8'hFF;
    a_data = 40'h12_3456_789A;
    b_mode = 1'b0; b_hold = 1'b0; b_sel = 3'd0; b_mask = 6'h3F; b_data = 30'h0;
    #3;
    checks++; if (a_dout !== 5'd0) begin errors++; $display("FAIL reset_data got %0d want 0", a_dout); end
    checks++; if (a_ch !== 3'd0) begin errors++; $display("FAIL reset_ch got %0d want 0", a_ch); end
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", a_valid); end
    checks++; if (a_wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", a_wrap); end
    clk_edge();
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_held_valid got %b want 0", a_valid); end
  endtask

  task automatic test_manual_sweep();
    do_reset(1'b0);
    for (int k = 0; k < 8; k++) a_data[k*5 +: 5] = 5'(k + 10);
    for (int s = 0; s < 8; s++) begin
      a_sel = 3'(s);
      model_edge();
      clk_edge();
      checks++; if (a_dout !== 5'(s + 10)) begin errors++; $display("FAIL manual_data sel=%0d got %0d want %0d", s, a_dout, s + 10); end
      checks++; if (a_ch !== 3'(s)) begin errors++; $display("FAIL manual_ch got %0d want %0d", a_ch, s); end
      checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL manual_valid got %b want 1", a_valid); end
    end
    a_sel = 3'd0;
    clk_edge();
    a_data[4:0] = 5'd21;
    model_edge();
    clk_edge();
    checks++; if (a_dout !== 5'd21) begin errors++; $display("FAIL manual_live got %0d want 21", a_dout); end
  endtask

  task automatic test_scan_sequence();
    do_reset(1'b1);
    for (int e = 1; e <= 36; e++) begin
      a_data = 40'({$urandom, $urandom});
      model_edge();
      clk_edge();
      checks++; if (a_ch !== 3'(((e - 1) / 4) % 8)) begin errors++; $display("FAIL scan_ch edge=%0d got %0d want %0d", e, a_ch, ((e - 1) / 4) % 8); end
      checks++; if (a_wrap !== (e == 33)) begin errors++; $display("FAIL scan_wrap edge=%0d got %b want %b", e, a_wrap, (e == 33)); end
      checks++; if (a_dout !== m_data || a_valid !== 1'b1) begin errors++; $display("FAIL scan_data edge=%0d got %0d/%b want %0d/1", e, a_dout, a_valid, m_data); end
    end
  endtask

  task automatic test_hold();
    logic [4:0] snap_data;
    do_reset(1'b1);
    for (int e = 1; e <= 14; e++) begin
      a_data = 40'({$urandom, $urandom});
      model_edge();
      clk_edge();
    end
    checks++; if (a_ch !== 3'd3) begin errors++; $display("FAIL hold_pre_ch got %0d want 3", a_ch); end
    snap_data = a_dout;
    a_hold = 1'b1;
    for (int e = 0; e < 5; e++) begin
      a_data = 40'({$urandom, $urandom});
      model_edge();
      clk_edge();
      checks++; if (a_ch !== 3'd3 || a_dout !== snap_data || a_valid !== 1'b1 || a_wrap !== 1'b0) begin
        errors++; $display("FAIL hold_frozen got ch=%0d d=%0d v=%b w=%b want ch=3 d=%0d v=1 w=0", a_ch, a_dout, a_valid, a_wrap, snap_data);
      end
    end
    a_hold = 1'b0;
    for (int e = 0; e < 3; e++) begin
      a_data = 40'({$urandom, $urandom});
      model_edge();
      clk_edge();
      checks++; if (a_ch !== ((e < 2) ? 3'd3 : 3'd4)) begin errors++; $display("FAIL hold_resume step=%0d got %0d want %0d", e, a_ch, (e < 2) ? 3 : 4); end
      checks++; if (a_dout !== m_data) begin errors++; $display("FAIL hold_resume_data got %0d want %0d", a_dout, m_data); end
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b1);
    for (int e = 1; e <= 22; e++) begin
      a_data = 40'({$urandom, $urandom});
      clk_edge();
    end
    checks++; if (a_ch !== 3'd5) begin errors++; $display("FAIL areset_pre_ch got %0d want 5", a_ch); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (a_dout !== 5'd0 || a_ch !== 3'd0 || a_valid !== 1'b0) begin
      errors++; $display("FAIL areset_clear got d=%0d ch=%0d v=%b want 0/0/0", a_dout, a_ch, a_valid);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      model_edge();
      clk_edge();
      checks++; if (a_ch !== ((e <= 4) ? 3'd0 : 3'd1) || a_dout !== m_data || a_valid !== 1'b1) begin
        errors++; $display("FAIL areset_restart edge=%0d got ch=%0d d=%0d want ch=%0d d=%0d", e, a_ch, a_dout, (e <= 4) ? 0 : 1, m_data);
      end
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    do_reset(1'b0);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) a_mode = ~a_mode;
      a_hold = ($urandom_range(0, 5) == 0);
      a_sel  = 3'($urandom);
      a_data = 40'({$urandom, $urandom});
`ifdef MUX_SCAN_MASK_EN
      a_mask = 8'hFF;
`else
      a_mask = 8'($urandom);
`endif
      model_edge();
      clk_edge();
      checks++;
      if (a_dout !== m_data || a_ch !== m_ch || a_valid !== m_valid || a_wrap !== m_wrap) begin
        errors++;
        if (bad < 10) $display("FAIL random i=%0d got d=%0d ch=%0d v=%b w=%b want d=%0d ch=%0d v=%b w=%b",
                               i, a_dout, a_ch, a_valid, a_wrap, m_data, m_ch, m_valid, m_wrap);
        bad++;
      end
    end
    a_mode = 1'b0; a_hold = 1'b0; a_mask = 8'hFF;
  endtask

  task automatic test_out_of_range();
    b_mode = 1'b0; b_hold = 1'b0;
    b_data = 30'($urandom);
    b_sel  = 3'd2;
    clk_edge();
    checks++; if (b_dout !== b_data[14:10] || b_ch !== 3'd2 || b_valid !== 1'b1) begin
      errors++; $display("FAIL oor_base got d=%0d ch=%0d v=%b want d=%0d ch=2 v=1", b_dout, b_ch, b_valid, b_data[14:10]);
    end
    for (int s = 6; s < 8; s++) begin
      b_sel = 3'(s);
      clk_edge();
      checks++; if (b_dout !== 5'd0 || b_valid !== 1'b0 || b_ch !== 3'd2) begin
        errors++; $display("FAIL oor_sel%0d got d=%0d ch=%0d v=%b want d=0 ch=2 v=0", s, b_dout, b_ch, b_valid);
      end
    end
  endtask

`ifdef MUX_SCAN_MASK_EN
  task automatic test_mask();
    int order [4];
    order[0] = 0; order[1] = 2; order[2] = 7; order[3] = 0;
    a_mask = 8'b1000_0101;
    do_reset(1'b1);
    for (int e = 1; e <= 13; e++) begin
      clk_edge();
      checks++; if (a_ch !== 3'(order[(e - 1) / 4])) begin errors++; $display("FAIL mask_order edge=%0d got %0d want %0d", e, a_ch, order[(e - 1) / 4]); end
      checks++; if (a_wrap !== (e == 13)) begin errors++; $display("FAIL mask_wrap edge=%0d got %b want %b", e, a_wrap, (e == 13)); end
    end
    a_mask = 8'h00;
    clk_edge();
    checks++; if (a_valid !== 1'b0 || a_dout !== 5'd0) begin errors++; $display("FAIL mask_none got d=%0d v=%b want 0/0", a_dout, a_valid); end
    a_mask = 8'b0000_0100;
    do_reset(1'b1);
    for (int e = 1; e <= 24; e++) begin
      clk_edge();
      if (e > 8) begin
        checks++; if (a_ch !== 3'd2) begin errors++; $display("FAIL mask_single_ch edge=%0d got %0d want 2", e, a_ch); end
        checks++; if (a_wrap !== ((e % 4) == 1)) begin errors++; $display("FAIL mask_single_wrap edge=%0d got %b want %b", e, a_wrap, ((e % 4) == 1)); end
      end
    end
    a_mask = 8'hFF;
  endtask
`endif

  initial begin
    test_reset();
    test_manual_sweep();
    test_scan_sequence();
    test_hold();
    test_async_reset();
    test_random();
    test_out_of_range();
`ifdef MUX_SCAN_MASK_EN
    test_mask();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
